// File: rtl/tuner_phy_pkg.sv
// Shared types and constants for the tuner PHY control slice.
// Holds the channel-arbiter state encoding and the fixed channel roles.
package tuner_phy_pkg;

   typedef enum logic [1:0] {
      CHAN_ARB_IDLE    = 2'd0,
      CHAN_ARB_REFRESH = 2'd1,
      CHAN_ARB_TUNE    = 2'd2,
      CHAN_ARB_COMMIT  = 2'd3
   } tuner_ctrl_chan_arb_state_e;

   localparam int CH_SEARCH = 0;
   localparam int CH_LOCK   = 1;
   localparam int CH_SCAN   = 2;

endpackage

// File: rtl/tuner_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above the pointer,
// wrapping around, reported both one-hot and as an index.
module tuner_rr_arbiter #(
   parameter  int NUM_CH = 3,
   localparam int IDX_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] i_req,
   input  logic [IDX_W-1:0]  i_ptr,
   output logic [NUM_CH-1:0] o_grant_oh,
   output logic [IDX_W-1:0]  o_grant_idx,
   output logic              o_grant_vld
);

   localparam logic [IDX_W:0] NUM_CH_W = (IDX_W+1)'(NUM_CH);

   logic [IDX_W:0] cand;

   // Walk NUM_CH candidates starting at the pointer; the first hit wins.
   always_comb begin
      o_grant_oh  = '0;
      o_grant_idx = '0;
      o_grant_vld = 1'b0;
      cand        = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cand = {1'b0, i_ptr} + (IDX_W+1)'(i);
         if (cand >= NUM_CH_W) begin
            cand = cand - NUM_CH_W;
         end
         if (!o_grant_vld && i_req[cand[IDX_W-1:0]]) begin
            o_grant_vld                  = 1'b1;
            o_grant_oh[cand[IDX_W-1:0]]  = 1'b1;
            o_grant_idx                  = cand[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/tuner_ctrl_chan_arb.sv
// Shares one tuner PHY among several tuning controllers, one tune->commit
// transaction per grant, with PHY refresh on owner change, watchdog and abort.
module tuner_ctrl_chan_arb
   import tuner_phy_pkg::*;
#(
   parameter int NUM_CH         = 3,
   parameter int DAC_WIDTH      = 8,
   parameter int ADC_WIDTH      = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [NUM_CH-1:0]             i_ch_active,
   input  logic [NUM_CH-1:0]             i_ch_tune_val,
   output logic [NUM_CH-1:0]             o_ch_tune_rdy,
   input  logic [NUM_CH*DAC_WIDTH-1:0]   i_ch_ring_tune,
   output logic [NUM_CH-1:0]             o_ch_commit_val,
   input  logic [NUM_CH-1:0]             i_ch_commit_rdy,
   output logic [ADC_WIDTH-1:0]          o_ch_pwr_commit,
   output logic [DAC_WIDTH-1:0]          o_ch_ring_tune_commit,
   output logic                          o_phy_tune_val,
   input  logic                          i_phy_tune_rdy,
   output logic [DAC_WIDTH-1:0]          o_phy_ring_tune,
   input  logic                          i_phy_commit_val,
   output logic                          o_phy_commit_rdy,
   input  logic [ADC_WIDTH-1:0]          i_phy_pwr_commit,
   input  logic [DAC_WIDTH-1:0]          i_phy_ring_tune_commit,
   output logic                          o_phy_refresh,
   output logic                          o_phy_pwr_detect_active,
   output logic [NUM_CH-1:0]             o_grant_oh,
   output logic                          o_timeout
);

   localparam int IDX_W = $clog2(NUM_CH);
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

   tuner_ctrl_chan_arb_state_e state_q, state_d;
   logic [IDX_W-1:0]  owner_q, owner_d;
   logic [NUM_CH-1:0] owner_oh_q, owner_oh_d;
   logic [IDX_W-1:0]  last_owner_q, last_owner_d;
   logic              last_vld_q, last_vld_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;
   logic              refresh_q, refresh_d;
   logic              timeout_q, timeout_d;

   logic [NUM_CH-1:0] arb_req;
   logic [NUM_CH-1:0] arb_grant_oh;
   logic [IDX_W-1:0]  arb_idx;
   logic              arb_vld;

   logic              owner_active;
   logic              busy;
   logic              abort;
   logic              tune_live;
   logic              commit_live;
   logic              tune_fire;
   logic              commit_fire;
   logic              wd_expire;
   logic [WD_W-1:0]   wdog_inc;
   logic [IDX_W-1:0]  owner_next;
   logic [DAC_WIDTH-1:0] owner_code;

   assign arb_req = i_ch_active & i_ch_tune_val;

   tuner_rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_rr_arbiter (
      .i_req       (arb_req),
      .i_ptr       (rr_ptr_q),
      .o_grant_oh  (arb_grant_oh),
      .o_grant_idx (arb_idx),
      .o_grant_vld (arb_vld)
   );

   // A deactivated owner kills its handshakes in the same cycle it drops.
   assign owner_active = |(i_ch_active & owner_oh_q);
   assign busy         = (state_q == CHAN_ARB_TUNE) || (state_q == CHAN_ARB_COMMIT);
   assign abort        = busy && !owner_active;
   assign tune_live    = !i_rst && (state_q == CHAN_ARB_TUNE) && owner_active;
   assign commit_live  = !i_rst && (state_q == CHAN_ARB_COMMIT) && owner_active;
   assign tune_fire    = o_phy_tune_val && i_phy_tune_rdy;
   assign commit_fire  = o_phy_commit_rdy && i_phy_commit_val;
   assign wdog_inc     = wdog_q + WD_W'(1);
   assign wd_expire    = commit_live && !commit_fire && (wdog_inc == WD_LIMIT);
   assign owner_next   = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);

   always_comb begin
      owner_code = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (owner_q == IDX_W'(k)) begin
            owner_code = i_ch_ring_tune[k*DAC_WIDTH +: DAC_WIDTH];
         end
      end
   end

   always_comb begin
      o_phy_tune_val   = 1'b0;
      o_ch_tune_rdy    = '0;
      o_phy_ring_tune  = '0;
      o_ch_commit_val  = '0;
      o_phy_commit_rdy = 1'b0;
      if (tune_live) begin
         o_phy_tune_val  = |(i_ch_tune_val & owner_oh_q);
         o_ch_tune_rdy   = owner_oh_q & {NUM_CH{i_phy_tune_rdy}};
         o_phy_ring_tune = owner_code;
      end
      if (commit_live) begin
         o_ch_commit_val  = owner_oh_q & {NUM_CH{i_phy_commit_val}};
         o_phy_commit_rdy = |(i_ch_commit_rdy & owner_oh_q);
      end
   end

   assign o_ch_pwr_commit         = i_phy_pwr_commit;
   assign o_ch_ring_tune_commit   = i_phy_ring_tune_commit;
   assign o_phy_refresh           = refresh_q && !i_rst;
   assign o_timeout               = timeout_q && !i_rst;
   assign o_phy_pwr_detect_active = (|i_ch_active) && !i_rst;
   assign o_grant_oh              = (!i_rst && state_q != CHAN_ARB_IDLE) ? owner_oh_q : '0;

   // Refresh is raised on entry to REFRESH and on any abandoned transaction,
   // so the registered pulse lines up with the cycle that follows the decision.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      owner_oh_d   = owner_oh_q;
      last_owner_d = last_owner_q;
      last_vld_d   = last_vld_q;
      rr_ptr_d     = rr_ptr_q;
      wdog_d       = wdog_q;
      refresh_d    = 1'b0;
      timeout_d    = 1'b0;
      case (state_q)
         CHAN_ARB_IDLE: begin
            if (arb_vld) begin
               owner_d    = arb_idx;
               owner_oh_d = arb_grant_oh;
               if (!last_vld_q || (arb_idx != last_owner_q)) begin
                  state_d   = CHAN_ARB_REFRESH;
                  refresh_d = 1'b1;
               end else begin
                  state_d = CHAN_ARB_TUNE;
               end
            end
         end
         CHAN_ARB_REFRESH: begin
            last_owner_d = owner_q;
            last_vld_d   = 1'b1;
            state_d      = CHAN_ARB_TUNE;
         end
         CHAN_ARB_TUNE: begin
            if (abort) begin
               refresh_d  = 1'b1;
               last_vld_d = 1'b0;
               state_d    = CHAN_ARB_IDLE;
            end else if (tune_fire) begin
               wdog_d  = '0;
               state_d = CHAN_ARB_COMMIT;
            end
         end
         CHAN_ARB_COMMIT: begin
            if (abort) begin
               refresh_d  = 1'b1;
               last_vld_d = 1'b0;
               state_d    = CHAN_ARB_IDLE;
            end else if (commit_fire) begin
               rr_ptr_d = owner_next;
               state_d  = CHAN_ARB_IDLE;
            end else if (wd_expire) begin
               timeout_d  = 1'b1;
               refresh_d  = 1'b1;
               last_vld_d = 1'b0;
               rr_ptr_d   = owner_next;
               state_d    = CHAN_ARB_IDLE;
            end else begin
               wdog_d = wdog_inc;
            end
         end
         default: begin
            state_d = CHAN_ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= CHAN_ARB_IDLE;
         owner_q      <= '0;
         owner_oh_q   <= '0;
         last_owner_q <= '0;
         last_vld_q   <= 1'b0;
         rr_ptr_q     <= '0;
         wdog_q       <= '0;
         refresh_q    <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         owner_oh_q   <= owner_oh_d;
         last_owner_q <= last_owner_d;
         last_vld_q   <= last_vld_d;
         rr_ptr_q     <= rr_ptr_d;
         wdog_q       <= wdog_d;
         refresh_q    <= refresh_d;
         timeout_q    <= timeout_d;
      end
   end

endmodule

// File: tb/tb_tuner_ctrl_chan_arb.sv
// Directed bench for tuner_ctrl_chan_arb: a per-cycle vector table for the
// single-channel flow, then hand-written multi-cycle corner-case sequences.
module tb_tuner_ctrl_chan_arb;

   logic        clk;
   logic        rst;
   logic [2:0]  active;
   logic [2:0]  tuneVal;
   logic [2:0]  tuneRdy;
   logic [23:0] ringTune;
   logic [2:0]  commitValOut;
   logic [2:0]  commitRdy;
   logic [7:0]  pwrCommitOut;
   logic [7:0]  ringCommitOut;
   logic        phyTuneVal;
   logic        phyTuneRdy;
   logic [7:0]  phyRingTune;
   logic        phyCommitVal;
   logic        phyCommitRdy;
   logic [7:0]  phyPwr;
   logic [7:0]  phyRingCommit;
   logic        refresh;
   logic        pwrDetect;
   logic [2:0]  grant;
   logic        timeout;

   int checks;
   int errors;
   logic [7:0] codes [3];

   typedef struct {
      logic       rst;
      logic [2:0] act;
      logic [2:0] tval;
      logic       prdy;
      logic       pcval;
      logic [2:0] crdy;
      logic [2:0] eGrant;
      logic       eRefresh;
      logic       eTimeout;
      logic       ePhyVal;
      logic [2:0] eTuneRdy;
      logic [2:0] eCommitVal;
      logic       ePhyCrdy;
      logic [7:0] eRing;
      logic       ePwrDet;
   } vec_t;

   vec_t vecs [10];

   tuner_ctrl_chan_arb #(
      .NUM_CH         (3),
      .DAC_WIDTH      (8),
      .ADC_WIDTH      (8),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .i_clk                   (clk),
      .i_rst                   (rst),
      .i_ch_active             (active),
      .i_ch_tune_val           (tuneVal),
      .o_ch_tune_rdy           (tuneRdy),
      .i_ch_ring_tune          (ringTune),
      .o_ch_commit_val         (commitValOut),
      .i_ch_commit_rdy         (commitRdy),
      .o_ch_pwr_commit         (pwrCommitOut),
      .o_ch_ring_tune_commit   (ringCommitOut),
      .o_phy_tune_val          (phyTuneVal),
      .i_phy_tune_rdy          (phyTuneRdy),
      .o_phy_ring_tune         (phyRingTune),
      .i_phy_commit_val        (phyCommitVal),
      .o_phy_commit_rdy        (phyCommitRdy),
      .i_phy_pwr_commit        (phyPwr),
      .i_phy_ring_tune_commit  (phyRingCommit),
      .o_phy_refresh           (refresh),
      .o_phy_pwr_detect_active (pwrDetect),
      .o_grant_oh              (grant),
      .o_timeout               (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One cycle: drive inputs just after the rising edge, sample at the falling edge.
   task automatic applyStimulus(input logic r, input logic [2:0] a, input logic [2:0] tv,
                                input logic pr, input logic pcv, input logic [2:0] cr);
      @(posedge clk);
      #1;
      rst          = r;
      active       = a;
      tuneVal      = tv;
      phyTuneRdy   = pr;
      phyCommitVal = pcv;
      commitRdy    = cr;
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic checkRow(input int r, input vec_t v);
      checkOutput($sformatf("row%0d grant", r), 8'(grant), 8'(v.eGrant));
      checkOutput($sformatf("row%0d refresh", r), 8'(refresh), 8'(v.eRefresh));
      checkOutput($sformatf("row%0d timeout", r), 8'(timeout), 8'(v.eTimeout));
      checkOutput($sformatf("row%0d phy_tune_val", r), 8'(phyTuneVal), 8'(v.ePhyVal));
      checkOutput($sformatf("row%0d ch_tune_rdy", r), 8'(tuneRdy), 8'(v.eTuneRdy));
      checkOutput($sformatf("row%0d ch_commit_val", r), 8'(commitValOut), 8'(v.eCommitVal));
      checkOutput($sformatf("row%0d phy_commit_rdy", r), 8'(phyCommitRdy), 8'(v.ePhyCrdy));
      checkOutput($sformatf("row%0d phy_ring_tune", r), phyRingTune, v.eRing);
      checkOutput($sformatf("row%0d pwr_detect", r), 8'(pwrDetect), 8'(v.ePwrDet));
      checkOutput($sformatf("row%0d pwr_commit", r), pwrCommitOut, 8'h33);
      checkOutput($sformatf("row%0d ring_commit", r), ringCommitOut, 8'h77);
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      codes[0]      = 8'h11;
      codes[1]      = 8'h5A;
      codes[2]      = 8'hC3;
      ringTune      = {codes[2], codes[1], codes[0]};
      phyPwr        = 8'h33;
      phyRingCommit = 8'h77;
      rst           = 1'b1;
      active        = '0;
      tuneVal       = '0;
      phyTuneRdy    = 1'b0;
      phyCommitVal  = 1'b0;
      commitRdy     = '0;

      // rst act tval prdy pcval crdy | grant ref to pval trdy cval pcrdy ring pdet
      vecs[0] = '{1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 8'h00, 1'b0};
      vecs[1] = '{1'b0, 3'b010, 3'b010, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{1'b0, 3'b010, 3'b010, 1'b0, 1'b0, 3'b000, 3'b010, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 8'h00, 1'b1};
      vecs[3] = '{1'b0, 3'b010, 3'b010, 1'b1, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 1'b1, 3'b010, 3'b000, 1'b0, 8'h5A, 1'b1};
      vecs[4] = '{1'b0, 3'b010, 3'b000, 1'b0, 1'b1, 3'b010, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 3'b010, 1'b1, 8'h00, 1'b1};
      vecs[5] = '{1'b0, 3'b010, 3'b010, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 8'h00, 1'b1};
      vecs[6] = '{1'b0, 3'b010, 3'b010, 1'b1, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 1'b1, 3'b010, 3'b000, 1'b0, 8'h5A, 1'b1};
      vecs[7] = '{1'b0, 3'b010, 3'b000, 1'b0, 1'b1, 3'b010, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 3'b010, 1'b1, 8'h00, 1'b1};
      vecs[8] = '{1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 8'h00, 1'b1};
      vecs[9] = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 8'h00, 1'b0};

      $display("[TB] single-channel vector table");
      for (int r = 0; r < 10; r++) begin
         applyStimulus(vecs[r].rst, vecs[r].act, vecs[r].tval, vecs[r].prdy, vecs[r].pcval, vecs[r].crdy);
         checkRow(r, vecs[r]);
      end

      // Round robin with every channel permanently requesting and the PHY always ready.
      $display("[TB] round-robin sequence");
      applyStimulus(1'b1, 3'b111, 3'b111, 1'b1, 1'b1, 3'b111);
      for (int k = 0; k < 4; k++) begin
         logic [2:0] e;
         e = 3'(1 << (k % 3));
         applyStimulus(1'b0, 3'b111, 3'b111, 1'b1, 1'b1, 3'b111);
         checkOutput($sformatf("rr%0d idle grant", k), 8'(grant), 8'h00);
         applyStimulus(1'b0, 3'b111, 3'b111, 1'b1, 1'b1, 3'b111);
         checkOutput($sformatf("rr%0d refresh grant", k), 8'(grant), 8'(e));
         checkOutput($sformatf("rr%0d refresh", k), 8'(refresh), 8'h01);
         checkOutput($sformatf("rr%0d refresh tune_val", k), 8'(phyTuneVal), 8'h00);
         applyStimulus(1'b0, 3'b111, 3'b111, 1'b1, 1'b1, 3'b111);
         checkOutput($sformatf("rr%0d tune grant", k), 8'(grant), 8'(e));
         checkOutput($sformatf("rr%0d tune refresh", k), 8'(refresh), 8'h00);
         checkOutput($sformatf("rr%0d tune_rdy", k), 8'(tuneRdy), 8'(e));
         checkOutput($sformatf("rr%0d ring", k), phyRingTune, codes[k % 3]);
         applyStimulus(1'b0, 3'b111, 3'b111, 1'b1, 1'b1, 3'b111);
         checkOutput($sformatf("rr%0d commit_val", k), 8'(commitValOut), 8'(e));
      end

      // Watchdog: PHY never commits, channel 0 times out after 8 COMMIT cycles.
      $display("[TB] watchdog sequence");
      applyStimulus(1'b1, 3'b011, 3'b011, 1'b1, 1'b0, 3'b011);
      applyStimulus(1'b0, 3'b011, 3'b011, 1'b1, 1'b0, 3'b011);
      checkOutput("wd idle grant", 8'(grant), 8'h00);
      applyStimulus(1'b0, 3'b011, 3'b011, 1'b1, 1'b0, 3'b011);
      checkOutput("wd refresh grant", 8'(grant), 8'h01);
      applyStimulus(1'b0, 3'b011, 3'b011, 1'b1, 1'b0, 3'b011);
      checkOutput("wd tune_rdy", 8'(tuneRdy), 8'h01);
      for (int n = 1; n <= 8; n++) begin
         applyStimulus(1'b0, 3'b011, 3'b011, 1'b1, 1'b0, 3'b011);
         checkOutput($sformatf("wd commit%0d timeout", n), 8'(timeout), 8'h00);
         checkOutput($sformatf("wd commit%0d grant", n), 8'(grant), 8'h01);
      end
      applyStimulus(1'b0, 3'b011, 3'b011, 1'b1, 1'b0, 3'b011);
      checkOutput("wd expire timeout", 8'(timeout), 8'h01);
      checkOutput("wd expire refresh", 8'(refresh), 8'h01);
      checkOutput("wd expire grant", 8'(grant), 8'h00);
      applyStimulus(1'b0, 3'b011, 3'b011, 1'b1, 1'b0, 3'b011);
      checkOutput("wd next grant", 8'(grant), 8'h02);
      checkOutput("wd next refresh", 8'(refresh), 8'h01);
      checkOutput("wd next timeout", 8'(timeout), 8'h00);
      checkOutput("wd next tune_val", 8'(phyTuneVal), 8'h00);

      // Abort: channel 0 deactivated while its commit is pending.
      $display("[TB] abort sequence");
      applyStimulus(1'b1, 3'b101, 3'b101, 1'b1, 1'b0, 3'b000);
      applyStimulus(1'b0, 3'b101, 3'b101, 1'b1, 1'b0, 3'b000);
      applyStimulus(1'b0, 3'b101, 3'b101, 1'b1, 1'b0, 3'b000);
      checkOutput("ab refresh grant", 8'(grant), 8'h01);
      applyStimulus(1'b0, 3'b101, 3'b101, 1'b1, 1'b0, 3'b000);
      applyStimulus(1'b0, 3'b101, 3'b101, 1'b1, 1'b1, 3'b000);
      checkOutput("ab commit_val live", 8'(commitValOut), 8'h01);
      checkOutput("ab commit_rdy live", 8'(phyCommitRdy), 8'h00);
      applyStimulus(1'b0, 3'b100, 3'b101, 1'b1, 1'b1, 3'b001);
      checkOutput("ab commit_val drop", 8'(commitValOut), 8'h00);
      checkOutput("ab commit_rdy drop", 8'(phyCommitRdy), 8'h00);
      checkOutput("ab drop refresh", 8'(refresh), 8'h00);
      applyStimulus(1'b0, 3'b100, 3'b101, 1'b1, 1'b0, 3'b000);
      checkOutput("ab after refresh", 8'(refresh), 8'h01);
      checkOutput("ab after grant", 8'(grant), 8'h00);
      checkOutput("ab after timeout", 8'(timeout), 8'h00);
      applyStimulus(1'b0, 3'b100, 3'b101, 1'b1, 1'b0, 3'b000);
      checkOutput("ab regrant", 8'(grant), 8'h04);
      checkOutput("ab regrant refresh", 8'(refresh), 8'h01);

      // Commit fires in exactly the cycle the watchdog would expire.
      $display("[TB] fire-at-expiry sequence");
      applyStimulus(1'b1, 3'b001, 3'b001, 1'b1, 1'b0, 3'b001);
      applyStimulus(1'b0, 3'b001, 3'b001, 1'b1, 1'b0, 3'b001);
      applyStimulus(1'b0, 3'b001, 3'b001, 1'b1, 1'b0, 3'b001);
      applyStimulus(1'b0, 3'b001, 3'b001, 1'b1, 1'b0, 3'b001);
      for (int n = 1; n <= 7; n++) begin
         applyStimulus(1'b0, 3'b001, 3'b001, 1'b1, 1'b0, 3'b001);
         checkOutput($sformatf("fx commit%0d timeout", n), 8'(timeout), 8'h00);
      end
      applyStimulus(1'b0, 3'b001, 3'b001, 1'b1, 1'b1, 3'b001);
      checkOutput("fx commit_val", 8'(commitValOut), 8'h01);
      checkOutput("fx commit_rdy", 8'(phyCommitRdy), 8'h01);
      applyStimulus(1'b0, 3'b001, 3'b001, 1'b1, 1'b0, 3'b001);
      checkOutput("fx no timeout", 8'(timeout), 8'h00);
      checkOutput("fx no refresh", 8'(refresh), 8'h00);
      checkOutput("fx idle grant", 8'(grant), 8'h00);
      applyStimulus(1'b0, 3'b001, 3'b001, 1'b1, 1'b0, 3'b001);
      checkOutput("fx repeat grant", 8'(grant), 8'h01);
      checkOutput("fx repeat refresh", 8'(refresh), 8'h00);
      checkOutput("fx repeat tune_val", 8'(phyTuneVal), 8'h01);

      // Reset in the middle of a same-channel repeat tune.
      $display("[TB] reset-in-tune sequence");
      applyStimulus(1'b1, 3'b001, 3'b001, 1'b1, 1'b1, 3'b001);
      applyStimulus(1'b0, 3'b001, 3'b001, 1'b1, 1'b1, 3'b001);
      applyStimulus(1'b0, 3'b001, 3'b001, 1'b1, 1'b1, 3'b001);
      applyStimulus(1'b0, 3'b001, 3'b001, 1'b1, 1'b1, 3'b001);
      applyStimulus(1'b0, 3'b001, 3'b001, 1'b1, 1'b1, 3'b001);
      checkOutput("rt commit_val", 8'(commitValOut), 8'h01);
      applyStimulus(1'b0, 3'b001, 3'b001, 1'b0, 1'b0, 3'b001);
      checkOutput("rt idle refresh", 8'(refresh), 8'h00);
      applyStimulus(1'b0, 3'b001, 3'b001, 1'b0, 1'b0, 3'b001);
      checkOutput("rt tune grant", 8'(grant), 8'h01);
      checkOutput("rt tune refresh", 8'(refresh), 8'h00);
      applyStimulus(1'b1, 3'b001, 3'b001, 1'b0, 1'b0, 3'b001);
      applyStimulus(1'b0, 3'b001, 3'b001, 1'b0, 1'b0, 3'b001);
      checkOutput("rt post grant", 8'(grant), 8'h00);
      checkOutput("rt post refresh", 8'(refresh), 8'h00);
      checkOutput("rt post timeout", 8'(timeout), 8'h00);
      checkOutput("rt post tune_val", 8'(phyTuneVal), 8'h00);
      checkOutput("rt post tune_rdy", 8'(tuneRdy), 8'h00);
      checkOutput("rt post commit_val", 8'(commitValOut), 8'h00);
      checkOutput("rt post commit_rdy", 8'(phyCommitRdy), 8'h00);
      applyStimulus(1'b0, 3'b001, 3'b001, 1'b0, 1'b0, 3'b001);
      checkOutput("rt regrant", 8'(grant), 8'h01);
      checkOutput("rt regrant refresh", 8'(refresh), 8'h01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
